ep_lookup_engine: RTL and testbench

//  Endpoint lookup stage that feeds the slot memory controller interface.

---
 rtl/ep_lookup_pkg.sv | 32 +++
 rtl/ep_lookup_engine_ram.sv | 28 ++
 rtl/ep_lookup_engine.sv | 156 +++++++++++++++
 tb/tb_ep_lookup_engine.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ep_lookup_pkg.sv
// Shared types for the endpoint lookup path and the slot memory controller interface.
// Holds the result struct, the default widths and the lookup FSM states.
package ep_lookup_pkg;

    localparam int unsigned DEF_EP_ID_W = 8;
    localparam int unsigned DEF_SLOT_W  = 15;

    typedef struct packed {
        logic                   hit;
        logic [DEF_SLOT_W-1:0]  slot;
        logic [DEF_EP_ID_W-1:0] ep_id;
    } ep_lookup_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ep_state_e;

    // A miss never exposes a stale slot index.
    function automatic ep_lookup_t make_result(
        input logic                   hit,
        input logic [DEF_SLOT_W-1:0]  slot,
        input logic [DEF_EP_ID_W-1:0] ep_id
    );
        ep_lookup_t r;
        r.hit   = hit;
        r.slot  = hit ? slot : '0;
        r.ep_id = ep_id;
        return r;
    endfunction

endpackage

// File: rtl/ep_lookup_engine_ram.sv
// Endpoint->slot table storage: 1R1W synchronous RAM, one-cycle read latency.
// Storage is not reset; the top clears it after every reset.
module slot_table_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W) - 1];
    logic [DATA_W-1:0] rdata_q;

    // Read-before-write: a read colliding with a write returns the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ep_lookup_engine.sv
// Endpoint lookup stage: clears the ep->slot table after reset, then serves lookups
// through a one-stage RAM pipeline into a 2-entry result FIFO with valid/ready flow control.
module ep_lookup_engine
    import ep_lookup_pkg::*;
#(
    parameter int unsigned EP_ID_W = DEF_EP_ID_W,
    parameter int unsigned SLOT_W  = DEF_SLOT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [EP_ID_W-1:0] req_ep_id,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output ep_lookup_t         rsp_lookup,
    input  logic               upd_valid,
    input  logic [EP_ID_W-1:0] upd_ep_id,
    input  logic               upd_hit,
    input  logic [SLOT_W-1:0]  upd_slot,
    output logic               init_done
);

    ep_state_e           state_q;
    logic [EP_ID_W-1:0]  cnt_q;
    logic                init_done_q;

    logic                ram_we;
    logic [EP_ID_W-1:0]  ram_waddr;
    logic [SLOT_W:0]     ram_wdata;
    logic [SLOT_W:0]     ram_rdata;

    logic                s1_valid_q;
    logic [EP_ID_W-1:0]  s1_ep_q;
    logic                s1_byp_q;
    logic [SLOT_W:0]     s1_byp_data_q;
    logic [SLOT_W:0]     s1_entry;
    ep_lookup_t          s1_res;

    ep_lookup_t          fifo_q [0:1];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          fifo_cnt_q;
    logic [1:0]          fifo_cnt_d;
    logic [1:0]          occupancy;

    logic                accept;
    logic                push;
    logic                pop;
    logic                s0_byp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else if (state_q == INIT) begin
            cnt_q <= cnt_q + EP_ID_W'(1);
            if (cnt_q == '1) begin
                state_q     <= RUN;
                init_done_q <= 1'b1;
            end
        end
    end

    assign init_done = init_done_q;

    // The clear sweep owns the write port; updates are ignored until RUN.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = cnt_q;
        ram_wdata = '0;
        if (state_q == INIT) begin
            ram_we = 1'b1;
        end else if (upd_valid) begin
            ram_we    = 1'b1;
            ram_waddr = upd_ep_id;
            ram_wdata = {upd_hit, upd_slot};
        end
    end

    slot_table_ram #(
        .ADDR_W (EP_ID_W),
        .DATA_W (SLOT_W + 1)
    ) u_table (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (req_ep_id),
        .rdata_o (ram_rdata)
    );

    assign rsp_valid = (fifo_cnt_q != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign push      = s1_valid_q;

    // Credit counts the FIFO slot freed by this cycle's pop so a stream sustains 1/cycle.
    assign occupancy = fifo_cnt_q + {1'b0, s1_valid_q} - {1'b0, pop};
    assign req_ready = (state_q == RUN) && (occupancy < 2'd2);
    assign accept    = req_valid && req_ready;

    // The RAM read at accept misses a same-cycle write; capture the update instead.
    assign s0_byp    = upd_valid && (upd_ep_id == req_ep_id);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_ep_q       <= '0;
            s1_byp_q      <= 1'b0;
            s1_byp_data_q <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_ep_q       <= req_ep_id;
                s1_byp_q      <= s0_byp;
                s1_byp_data_q <= {upd_hit, upd_slot};
            end
        end
    end

    assign s1_entry = s1_byp_q ? s1_byp_data_q : ram_rdata;
    assign s1_res   = make_result(s1_entry[SLOT_W], s1_entry[SLOT_W-1:0], s1_ep_q);

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 2'd1;
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= s1_res;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    assign rsp_lookup = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_ep_lookup_engine.sv
// Randomized self-checking bench for ep_lookup_engine against a table/queue reference model.
module tb_ep_lookup_engine;
    import ep_lookup_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_ep_id = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    ep_lookup_t  rsp_lookup;
    logic        upd_valid = 1'b0;
    logic [7:0]  upd_ep_id = '0;
    logic        upd_hit = 1'b0;
    logic [14:0] upd_slot = '0;
    logic        init_done;

    ep_lookup_engine #(.EP_ID_W(8), .SLOT_W(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ep_id  (req_ep_id),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_lookup (rsp_lookup),
        .upd_valid  (upd_valid),
        .upd_ep_id  (upd_ep_id),
        .upd_hit    (upd_hit),
        .upd_slot   (upd_slot),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        ep_lookup_t  res;
    } exp_t;

    logic [15:0] ref_tab [256];
    exp_t        exp_q [$];
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_pass;
    bit          last_acc;
    bit          last_pop;
    bit          prev_stall;
    ep_lookup_t  prev_rsp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic ep_lookup_t ref_lookup(input logic [7:0] id);
        ep_lookup_t r;
        r.hit   = ref_tab[id][15];
        r.slot  = ref_tab[id][15] ? ref_tab[id][14:0] : 15'd0;
        r.ep_id = id;
        return r;
    endfunction

    // One cycle: drive at negedge, sample #1 later, advance the model for the coming edge.
    task automatic step(input bit rv, input logic [7:0] rid, input bit rr,
                        input bit uv, input logic [7:0] uid, input bit uh, input logic [14:0] us);
        exp_t e;
        @(negedge clk);
        req_valid = rv; req_ep_id = rid; rsp_ready = rr;
        upd_valid = uv; upd_ep_id = uid; upd_hit = uh; upd_slot = us;
        #1;
        if (prev_stall) chk("hold", 64'(rsp_lookup), 64'(prev_rsp));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() > 0 && cyc >= exp_q[0].cyc + 2));
        last_pop = rsp_valid && rsp_ready;
        chk("req_ready", 64'(req_ready), 64'((int'(exp_q.size()) - int'(last_pop)) < 2));
        if (last_pop) begin
            if (exp_q.size() == 0) chk("rsp_extra", 64'(1), 64'(0));
            else begin
                e = exp_q.pop_front();
                chk("rsp_lookup", 64'(rsp_lookup), 64'(e.res));
            end
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_rsp   = rsp_lookup;
        last_acc   = req_valid && req_ready;
        if (uv) ref_tab[uid] = {uh, us};
        if (last_acc) begin
            e.cyc = cyc;
            e.res = ref_lookup(rid);
            exp_q.push_back(e);
        end
        cyc++;
    endtask

    task automatic idle(input bit rr);
        step(1'b0, 8'd0, rr, 1'b0, 8'd0, 1'b0, 15'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1);
        chk("drained", 64'(exp_q.size()), 64'(0));
    endtask

    // Counts negedges from rst_n release until init_done; budget-bounded.
    task automatic release_and_init(output int unsigned n);
        n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b1;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (n == 200) begin
                upd_valid = 1'b1; upd_ep_id = 8'h00; upd_hit = 1'b1; upd_slot = 15'h1234;
            end else begin
                upd_valid = 1'b0;
            end
            #1;
            if (n == 1 || n == 255) chk("ready_in_init", 64'(req_ready), 64'(0));
            if (init_done) break;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 256; i++) ref_tab[i] = '0;
        exp_q.delete();
        prev_stall = 1'b0;
    endtask

    initial begin
        int unsigned n;
        int unsigned acc_cnt;
        int unsigned pop_cnt;
        logic [7:0]  id;
        n_checks = 0; n_pass = 0; cyc = 0; prev_stall = 1'b0;

        // Reset, table clear timing.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_lookup", 64'(rsp_lookup), 64'(0));
        chk("rst_init_done", 64'(init_done), 64'(0));
        release_and_init(n);
        chk("init_cycles", 64'(n), 64'(256));

        // Install and look up; a miss returns slot 0. Update during INIT had no effect.
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h12, 1'b1, 15'h0ABC);
        step(1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0, 15'd0);
        step(1'b1, 8'h13, 1'b1, 1'b0, 8'h00, 1'b0, 15'd0);
        step(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 15'd0);
        drain();

        // Same-cycle and next-cycle update hazard.
        step(1'b1, 8'h05, 1'b1, 1'b1, 8'h05, 1'b1, 15'd7);
        step(1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 15'd0);
        drain();

        // Backpressure: only two lookups fit.
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 8'h00, 1'b0, 15'd0);
            acc_cnt += last_acc;
        end
        chk("bp_accepted", 64'(acc_cnt), 64'(2));
        drain();

        // Full-rate stream with sparse random updates.
        acc_cnt = 0; pop_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            id = 8'($urandom_range(0, 15));
            step(1'b1, id, 1'b1, ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15)),
                 1'($urandom), 15'($urandom));
            acc_cnt += last_acc;
            pop_cnt += last_pop;
        end
        chk("stream_accepts", 64'(acc_cnt), 64'(100));
        chk("stream_pops", 64'(pop_cnt), 64'(98));
        drain();

        // Random mix of valid, ready and colliding updates.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 8'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                 1'($urandom), 8'($urandom_range(0, 7)), 1'($urandom), 15'($urandom));
        end
        drain();

        // Reset with two buffered results; the mapping of 0x12 must be gone afterwards.
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h12, 1'b1, 15'h0ABC);
        step(1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 15'd0);
        step(1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 15'd0);
        idle(1'b0);
        idle(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_valid", 64'(rsp_valid), 64'(0));
        chk("rst_drop_ready", 64'(req_ready), 64'(0));
        chk("rst_drop_init", 64'(init_done), 64'(0));
        release_and_init(n);
        chk("reinit_cycles", 64'(n), 64'(256));
        step(1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0, 15'd0);
        step(1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 15'd0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
